// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: byte lanes, byte enables and load extension behind a
// valid/ready request side and a registered, wait-state memory port with optional two-beat split.
module lsu_mem_stage #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int MISALIGN_SPLIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int MW = 2 * NB;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [OW-1:0]     off_q, off_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    size_of = 4'd1;
      2'd1:    size_of = 4'd2;
      2'd2:    size_of = 4'd4;
      default: size_of = 4'd8;
    endcase
  endfunction

  // Lanes touched across both words; upper half is the second beat.
  function automatic logic [MW-1:0] lane_mask(input logic [3:0] sz, input logic [OW-1:0] off);
    lane_mask = ((MW'(1) << sz) - MW'(1)) << off;
  endfunction

  function automatic logic crosses(input logic [3:0] sz, input logic [OW-1:0] off);
    logic [4:0] end_b;
    end_b   = 5'(off) + {1'b0, sz};
    crosses = end_b > 5'(NB);
  endfunction

  logic              req_legal, req_cross, cur_cross;
  logic [MW-1:0]     req_mask, cur_mask;
  logic [2*XLEN-1:0] req_rot;

  always_comb begin
    if (req_is_store) begin
      req_legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11 || XLEN == 64);
    end else begin
      req_legal = (req_funct3 != 3'b111) &&
                  ((req_funct3 != 3'b011 && req_funct3 != 3'b110) || XLEN == 64);
    end
    req_cross = crosses(size_of(req_funct3), req_addr[OW-1:0]);
    req_mask  = lane_mask(size_of(req_funct3), req_addr[OW-1:0]);
    req_rot   = {req_wdata, req_wdata} << {req_addr[OW-1:0], 3'b000};
    cur_cross = crosses(size_of(funct3_q), off_q);
    cur_mask  = lane_mask(size_of(funct3_q), off_q);
  end

  logic [XLEN-1:0]   ld_lo, ld_hi, ld_raw, ld_shl, ld_ext;
  logic [2*XLEN-1:0] ld_pair;
  logic [6:0]        ext_sh;

  // Final load value, computed in the cycle the last beat completes.
  always_comb begin
    ld_lo   = (state_q == BEAT0) ? mem_rdata : lo_q;
    ld_hi   = (state_q == BEAT1) ? mem_rdata : '0;
    ld_pair = {ld_hi, ld_lo} >> {off_q, 3'b000};
    ld_raw  = ld_pair[XLEN-1:0];
    ext_sh  = 7'(XLEN) - {size_of(funct3_q), 3'b000};
    ld_shl  = ld_raw << ext_sh;
    ld_ext  = funct3_q[2] ? (ld_shl >> ext_sh) : $unsigned($signed(ld_shl) >>> ext_sh);
    if (is_store_q) ld_ext = '0;
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    lo_d         = lo_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          off_d      = req_addr[OW-1:0];
          lo_d       = '0;
          if (!req_legal || (req_cross && MISALIGN_SPLIT == 0)) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d     = BEAT0;
            resp_err_d  = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = req_is_store;
            mem_addr_d  = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
            mem_be_d    = req_mask[NB-1:0];
            mem_wdata_d = req_rot[2*XLEN-1:XLEN];
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          if (!is_store_q) lo_d = mem_rdata;
          if (cur_cross) begin
            state_d    = BEAT1;
            mem_addr_d = mem_addr_q + ADDR_W'(NB);
            mem_be_d   = cur_mask[MW-1:NB];
          end else begin
            state_d      = RESP;
            mem_req_d    = 1'b0;
            mem_we_d     = 1'b0;
            mem_be_d     = '0;
            resp_rdata_d = ld_ext;
          end
        end
      end
      BEAT1: begin
        if (mem_ready) begin
          state_d      = RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_be_d     = '0;
          resp_rdata_d = ld_ext;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      lo_q         <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      lo_q         <= lo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage at XLEN=32: split-enabled unit on a byte-enable memory model,
// plus a split-disabled unit for misaligned error responses.
module tb_lsu_mem_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_valid1, req_is_store, ready_en;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, mem_req, mem_we, mem_ready;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        req_ready1, resp_valid1, resp_err1, mem_req1, mem_we1;
  logic [31:0] resp_rdata1, mem_addr1, mem_wdata1;
  logic [3:0]  mem_be1;

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .MISALIGN_SPLIT(0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1), .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_be(mem_be1), .mem_wdata(mem_wdata1), .mem_ready(1'b1), .mem_rdata(32'h0)
  );

  // 64-word memory covering 0x100..0x1FF, written only through the DUT
  logic [31:0] mem [0:63];
  assign mem_ready = ready_en;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk)
    if (mem_req && mem_we && mem_ready)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_q[$];
  exp_t exp_e;
  int tests = 0;
  int fails = 0;

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected: rdata=%h err=%b, no response outstanding", resp_rdata, resp_err);
      end else begin
        exp_e = exp_q.pop_front();
        if (resp_rdata !== exp_e.rdata || resp_err !== exp_e.err) begin
          fails++;
          $display("FAIL resp_data: got rdata=%h err=%b, want rdata=%h err=%b",
                   resp_rdata, resp_err, exp_e.rdata, exp_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
  endtask

  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
    bit seen = 1'b0;
    exp_q.push_back({er, ee});
    drive(st, f3, a, wd);
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_valid) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL op_timeout: addr=%h f3=%b got no resp_valid, want one within 12 cycles", a, f3);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0; ready_en = 1'b1;
    req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0) begin
      fails++;
      $display("FAIL reset_ctrl: ready=%b mem_req=%b we=%b be=%b, want 1 0 0 0", req_ready, mem_req, mem_we, mem_be);
    end
    tests++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b, want 0 0 0", resp_valid, resp_rdata, resp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: ready=%b ready1=%b, want 1 1", req_ready, req_ready1);
    end
  endtask

  task automatic test_store_word();
    exp_q.push_back({32'h0, 1'b0});
    drive(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1111 || mem_wdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL sw_beat: req=%b we=%b addr=%h be=%b wdata=%h, want 1 1 00000100 1111 deadbeef",
               mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    tests++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL sw_busy: ready=%b resp_valid=%b, want 0 0", req_ready, resp_valid);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL sw_latency: resp_valid=%b mem_req=%b in cycle 2, want 1 0", resp_valid, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_store_byte();
    exp_q.push_back({32'h0, 1'b0});
    drive(1'b1, 3'b000, 32'h103, 32'h000000A5);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_addr !== 32'h100 || mem_be !== 4'b1000 || mem_wdata[31:24] !== 8'hA5 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL sb_beat: addr=%h be=%b wdata=%h we=%b, want 00000100 1000 a5xxxxxx 1",
               mem_addr, mem_be, mem_wdata, mem_we);
    end
    repeat (2) @(negedge clk);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hA5ADBEEF, 1'b0);
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t [6];
    logic [31:0] ad_t [6];
    logic [31:0] ex_t [6];
    f3_t = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b000, 3'b010};
    ad_t = '{32'h102, 32'h102, 32'h101, 32'h103, 32'h103, 32'h100};
    ex_t = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'h00000080, 32'hFFFFFF80, 32'h80011234};
    do_op(1'b1, 3'b010, 32'h100, 32'h80011234, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) do_op(1'b0, f3_t[i], ad_t[i], 32'h0, ex_t[i], 1'b0);
  endtask

  task automatic test_split();
    do_op(1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b0);
    do_op(1'b1, 3'b010, 32'h104, 32'h55667788, 32'h0, 1'b0);
    exp_q.push_back({32'h77881122, 1'b0});
    drive(1'b0, 3'b010, 32'h102, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_be !== 4'b1100) begin
      fails++;
      $display("FAIL split_beat0: req=%b we=%b addr=%h be=%b, want 1 0 00000100 1100", mem_req, mem_we, mem_addr, mem_be);
    end
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_be !== 4'b0011 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL split_beat1: req=%b addr=%h be=%b resp_valid=%b, want 1 00000104 0011 0",
               mem_req, mem_addr, mem_be, resp_valid);
    end
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL split_latency: resp_valid=%b in cycle 3, want 1", resp_valid);
    end
    @(negedge clk);
    do_op(1'b1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 1'b0);
    do_op(1'b0, 3'b101, 32'h103, 32'h0, 32'h0000BEEF, 1'b0);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hEF223344, 1'b0);
  endtask

  task automatic test_errors();
    logic        st_t [4];
    logic [2:0]  f3_t [4];
    req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = 32'h0;
    req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    tests++;
    if (resp_valid1 !== 1'b1 || resp_err1 !== 1'b1 || mem_req1 !== 1'b0 || resp_rdata1 !== 32'h0) begin
      fails++;
      $display("FAIL nosplit_err: valid=%b err=%b mem_req=%b rdata=%h, want 1 1 0 0",
               resp_valid1, resp_err1, mem_req1, resp_rdata1);
    end
    @(negedge clk);
    tests++;
    if (resp_valid1 !== 1'b0 || req_ready1 !== 1'b1 || mem_req1 !== 1'b0 || mem_we1 !== 1'b0 ||
        mem_be1 !== 4'h0 || mem_addr1 !== 32'h0 || mem_wdata1 !== 32'h0) begin
      fails++;
      $display("FAIL nosplit_after: valid=%b ready=%b req=%b we=%b be=%b addr=%h wdata=%h, want 0 1 0 0 0 0 0",
               resp_valid1, req_ready1, mem_req1, mem_we1, mem_be1, mem_addr1, mem_wdata1);
    end
    st_t = '{1'b0, 1'b1, 1'b0, 1'b1};
    f3_t = '{3'b011, 3'b100, 3'b110, 3'b011};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'h0, 1'b1});
      drive(st_t[i], f3_t[i], 32'h100, 32'h12345678);
      @(negedge clk);
      req_valid = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL illegal_%0d: resp_valid=%b mem_req=%b in cycle 1, want 1 0", i, resp_valid, mem_req);
      end
      @(negedge clk);
      tests++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL illegal_idle_%0d: mem_req=%b ready=%b, want 0 1", i, mem_req, req_ready);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_q.push_back({32'h0, 1'b0});
    ready_en = 1'b0;
    drive(1'b1, 3'b010, 32'h108, 32'h12345678);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h108 || mem_be !== 4'hF ||
          mem_wdata !== 32'h12345678 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL wait_hold_c%0d: req=%b we=%b addr=%h be=%b wdata=%h ready=%b rv=%b, want 1 1 00000108 1111 12345678 0 0",
                 c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready, resp_valid);
      end
    end
    ready_en = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_done: resp_valid=%b after mem_ready, want 1", resp_valid);
    end
    @(negedge clk);
    do_op(1'b0, 3'b010, 32'h108, 32'h0, 32'h12345678, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [8:0] pat = '0;
    for (int i = 0; i < 3; i++) exp_q.push_back({32'hEF223344, 1'b0});
    drive(1'b0, 3'b010, 32'h100, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) pat[c] = 1'b1;
    end
    req_valid = 1'b0;
    tests++;
    if (pat !== 9'b100100100) begin
      fails++;
      $display("FAIL back_to_back: resp cycle pattern=%b, want 100100100", pat);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    drive(1'b1, 3'b010, 32'h10E, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (mem_addr !== 32'h10C || mem_be !== 4'b1100 || mem_wdata !== 32'hF00DCAFE) begin
      fails++;
      $display("FAIL rst_beat0: addr=%h be=%b wdata=%h, want 0000010c 1100 f00dcafe", mem_addr, mem_be, mem_wdata);
    end
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h110 || mem_be !== 4'b0011 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL rst_beat1: req=%b addr=%h be=%b we=%b, want 1 00000110 0011 1", mem_req, mem_addr, mem_be, mem_we);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: req=%b we=%b be=%b resp_valid=%b, want 0 0 0 0", mem_req, mem_we, mem_be, resp_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid || mem_req) seen = 1'b1;
    end
    tests++;
    if (seen || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_after: activity seen=%b ready=%b, want 0 1", seen, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_split();
    test_errors();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
